// File: rtl/fixed_point_pkg.sv
// Shared constants and helpers for the Q/N sign-magnitude fixed-point datapath.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fixed_point_pkg;

    // Default format: Q15 fraction inside a 32-bit sign-magnitude word.
    localparam int FP_Q_DEFAULT = 15;
    localparam int FP_N_DEFAULT = 32;

    // Zero is always represented with a clear sign bit.
    localparam logic        FP_POS_ZERO_SIGN = 1'b0;
    localparam logic [63:0] FP_POS_ZERO      = 64'd0;

    // Bit position of the sign in an n-bit word.
    function automatic int sign_idx(input int n);
        return n - 1;
    endfunction

    // Largest representable magnitude, 2^(n-1)-1, for words up to 64 bits.
    function automatic logic [63:0] max_mag(input int n);
        return (64'd1 << (n - 1)) - 64'd1;
    endfunction

endpackage

// File: rtl/fixed_point_sub_core.sv
// Combinational sign-magnitude add/subtract of pre-decoded operands with overflow flag.
// Latency: 0 cycles (pure combinational, feeds the stage-2 register).
// Backpressure: none; build option FIXED_POINT_SUB_SATURATE_EN saturates on overflow instead of wrapping.
module fixed_point_sub_core
    import fixed_point_pkg::*;
#(
    parameter int N = FP_N_DEFAULT
) (
    input  logic         a_sign,
    input  logic         b_sign_eff,
    input  logic         a_gt,
    input  logic [N-2:0] a_mag,
    input  logic [N-2:0] b_mag,
    output logic [N-1:0] c,
    output logic         ovf
);

`ifdef FIXED_POINT_SUB_SATURATE_EN
    localparam logic [63:0]  MAX_MAG_W = max_mag(N);
    localparam logic [N-2:0] MAX_MAG   = MAX_MAG_W[N-2:0];
`endif

    logic [N-1:0] sum_w;
    logic [N-2:0] diff_w;
    logic [N-2:0] mag;
    logic         sign;

    assign sum_w  = {1'b0, a_mag} + {1'b0, b_mag};
    assign diff_w = a_gt ? (a_mag - b_mag) : (b_mag - a_mag);

    // Select add or subtract path, pick result sign, and canonicalise zero to +0.
    always_comb begin
        mag  = '0;
        sign = 1'b0;
        ovf  = 1'b0;
        if (a_sign == b_sign_eff) begin
            sign = a_sign;
            ovf  = sum_w[N-1];
`ifdef FIXED_POINT_SUB_SATURATE_EN
            mag  = sum_w[N-1] ? MAX_MAG : sum_w[N-2:0];
`else
            mag  = sum_w[N-2:0];
`endif
        end else begin
            // Equal magnitudes give a_gt=0 and a zero difference, fixed up below.
            mag  = diff_w;
            sign = a_gt ? a_sign : b_sign_eff;
        end
        if (mag == '0) begin
            sign = FP_POS_ZERO_SIGN;
        end
        c = {sign, mag};
    end

endmodule

// File: rtl/fixed_point_subtractor_pipe.sv
// Two-stage pipelined sign-magnitude fixed-point subtractor c = a - b over valid/ready streams.
// Latency: 2 cycles from accepted operand pair to out_valid; 1 pair/cycle throughput.
// Backpressure: in_ready is combinational from out_ready; stalled stages hold. Option: FIXED_POINT_SUB_SATURATE_EN.
module fixed_point_subtractor_pipe
    import fixed_point_pkg::*;
#(
    parameter int Q = FP_Q_DEFAULT,
    parameter int N = FP_N_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] c,
    output logic         ovf
);

    localparam int SI = sign_idx(N);

    // Q only documents the binary point; the arithmetic is identical for any Q.
    if (N < 3 || Q > N - 1) begin : g_param_check
        $error("fixed_point_subtractor_pipe: need N >= 3 and Q <= N-1");
    end

    typedef struct packed {
        logic         a_sign;
        logic         b_sign_eff;
        logic         a_gt;
        logic [N-2:0] a_mag;
        logic [N-2:0] b_mag;
    } s1_t;

    s1_t          s1_dat;
    s1_t          s1_nxt;
    logic         s1_vld;
    logic         s1_adv;
    logic         s2_adv;
    logic [N-1:0] c_nxt;
    logic         ovf_nxt;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_vld || s2_adv;
    assign in_ready = s1_adv;

    // Decode operands: effective subtrahend sign and magnitude compare.
    always_comb begin
        s1_nxt            = '0;
        s1_nxt.a_sign     = a[SI];
        s1_nxt.b_sign_eff = ~b[SI];
        s1_nxt.a_mag      = a[N-2:0];
        s1_nxt.b_mag      = b[N-2:0];
        s1_nxt.a_gt       = (a[N-2:0] > b[N-2:0]);
    end

    // Stage 1 register: loads whenever it can advance, holds while stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld <= 1'b0;
            s1_dat <= '0;
        end else if (s1_adv) begin
            s1_vld <= in_valid;
            if (in_valid) begin
                s1_dat <= s1_nxt;
            end
        end
    end

    fixed_point_sub_core #(
        .N (N)
    ) u_core (
        .a_sign     (s1_dat.a_sign),
        .b_sign_eff (s1_dat.b_sign_eff),
        .a_gt       (s1_dat.a_gt),
        .a_mag      (s1_dat.a_mag),
        .b_mag      (s1_dat.b_mag),
        .c          (c_nxt),
        .ovf        (ovf_nxt)
    );

    // Stage 2 register: result and valid update only when downstream can take it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            c         <= FP_POS_ZERO[N-1:0];
            ovf       <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_vld;
            if (s1_vld) begin
                c   <= c_nxt;
                ovf <= ovf_nxt;
            end
        end
    end

endmodule
